// File: rtl/alsu_cmd_sequencer_if.sv
// Command/issue bundle between the ALSU command sequencer and its neighbours.
// The master side presents packed command words and the stall input. The slave
// side, the sequencer itself, drives the ALSU input word and its status.
interface alsu_cmd_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [16:0]         cmd_data;
  logic                hold;
  logic [2:0]          alsu_opcode;
  logic signed [2:0]   alsu_A;
  logic signed [2:0]   alsu_B;
  logic                alsu_cin;
  logic                alsu_red_op_A;
  logic                alsu_red_op_B;
  logic                alsu_bypass_A;
  logic                alsu_bypass_B;
  logic                alsu_direction;
  logic                alsu_serial_in;
  logic                issue_valid;
  logic                seq_busy;
  logic                seq_done;
  logic [CW-1:0]       fifo_count;

  modport master (
    output cmd_valid, cmd_data, hold,
    input  cmd_ready, alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_red_op_A,
           alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction,
           alsu_serial_in, issue_valid, seq_busy, seq_done, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_data, hold,
    output cmd_ready, alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_red_op_A,
           alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction,
           alsu_serial_in, issue_valid, seq_busy, seq_done, fifo_count
  );
endinterface

// File: rtl/alsu_cmd_sequencer.sv
// ALSU command sequencer.
// Buffers packed command words in a small FIFO and issues one word per clock
// onto the ALSU input pins. A seq_mode command expands into the fixed burst
// OR, XOR, ADD, MULT, SHIFT, ROTATE on its operands. The low 16 bits of a
// command word use the same layout as the issued ALSU word, so a single
// command is issued by copying them.
module alsu_cmd_sequencer #(
  parameter int         DEPTH       = 4,
  parameter logic [2:0] IDLE_OPCODE = 3'b000
) (
  input logic                 clk,
  input logic                 rst,
  alsu_cmd_sequencer_if.slave bus
);
  localparam int             AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
  localparam logic [AW-1:0]  PTR_ONE    = AW'(1);
  localparam logic [15:0]    IDLE_WORD  = {IDLE_OPCODE, 13'd0};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    SEQ    = 2'd2
  } state_t;

  // Opcode issued at a given burst step
  function automatic logic [2:0] seq_opcode(input logic [2:0] step);
    case (step)
      3'd0:    return 3'd0;  // OR
      3'd1:    return 3'd1;  // XOR
      3'd2:    return 3'd2;  // ADD
      3'd3:    return 3'd3;  // MULT
      3'd4:    return 3'd4;  // SHIFT
      3'd5:    return 3'd5;  // ROTATE
      default: return IDLE_OPCODE;
    endcase
  endfunction

  // Operand/control fields kept for a burst; reduction and bypass flags are
  // cleared so every burst step really exercises the arithmetic/shift path
  function automatic logic [12:0] burst_fields(input logic [16:0] cmd);
    return {cmd[12:7], cmd[6], 4'b0000, cmd[1:0]};
  endfunction

  logic [16:0]    mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  state_t         state_r;
  logic [2:0]     step_r;
  logic [12:0]    burst_r;
  logic [15:0]    word_r;
  logic           issue_valid_r;
  logic           seq_busy_r;
  logic           seq_done_r;

  logic           full_s;
  logic           empty_s;
  logic           push_s;
  logic           pop_s;
  logic           burst_run_s;
  logic [16:0]    head_s;

  // A full FIFO refuses new words even when a pop happens in the same cycle
  assign full_s      = (count_r == FULL_COUNT);
  assign empty_s     = (count_r == {CW{1'b0}});
  assign push_s      = bus.cmd_valid && !full_s;
  assign burst_run_s = (state_r == SEQ) && (step_r < 3'd5);
  assign pop_s       = !bus.hold && !burst_run_s && !empty_s;
  assign head_s      = mem_r[rd_ptr_r];

  assign bus.cmd_ready      = !full_s;
  assign bus.fifo_count     = count_r;
  assign bus.alsu_opcode    = word_r[15:13];
  assign bus.alsu_A         = $signed(word_r[12:10]);
  assign bus.alsu_B         = $signed(word_r[9:7]);
  assign bus.alsu_cin       = word_r[6];
  assign bus.alsu_red_op_A  = word_r[5];
  assign bus.alsu_red_op_B  = word_r[4];
  assign bus.alsu_bypass_A  = word_r[3];
  assign bus.alsu_bypass_B  = word_r[2];
  assign bus.alsu_direction = word_r[1];
  assign bus.alsu_serial_in = word_r[0];
  assign bus.issue_valid    = issue_valid_r;
  assign bus.seq_busy       = seq_busy_r;
  assign bus.seq_done       = seq_done_r;

  // FIFO storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.cmd_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue state machine with registered ALSU word and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      step_r        <= 3'd0;
      burst_r       <= 13'd0;
      word_r        <= IDLE_WORD;
      issue_valid_r <= 1'b0;
      seq_busy_r    <= 1'b0;
      seq_done_r    <= 1'b0;
    end else if (bus.hold) begin
      // Stall: everything frozen, ALSU sees the idle word, busy keeps its value
      word_r        <= IDLE_WORD;
      issue_valid_r <= 1'b0;
      seq_done_r    <= 1'b0;
    end else if (burst_run_s) begin
      step_r        <= step_r + 3'd1;
      word_r        <= {seq_opcode(step_r + 3'd1), burst_r};
      issue_valid_r <= 1'b1;
      seq_busy_r    <= 1'b1;
      seq_done_r    <= (step_r == 3'd4);
    end else if (!empty_s) begin
      step_r        <= 3'd0;
      issue_valid_r <= 1'b1;
      seq_done_r    <= 1'b0;
      if (head_s[16]) begin
        state_r    <= SEQ;
        burst_r    <= burst_fields(head_s);
        word_r     <= {seq_opcode(3'd0), burst_fields(head_s)};
        seq_busy_r <= 1'b1;
      end else begin
        state_r    <= SINGLE;
        word_r     <= head_s[15:0];
        seq_busy_r <= 1'b0;
      end
    end else begin
      state_r       <= IDLE;
      step_r        <= 3'd0;
      word_r        <= IDLE_WORD;
      issue_valid_r <= 1'b0;
      seq_busy_r    <= 1'b0;
      seq_done_r    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// Testbench for alsu_cmd_sequencer: directed scenarios plus random traffic,
// checked by a scoreboard fed from a queue-based reference model.
module tb_alsu_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [18:0]   out;    // {issue_valid, seq_busy, seq_done, 16-bit ALSU word}
    logic          ready;
    logic [CW-1:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  exp_t        exp_q[$];
  logic [16:0] pend_q[$];   // commands accepted but not yet started
  logic [15:0] burst_q[$];  // burst words still to issue
  bit          last_busy;
  exp_t        mon_e;

  alsu_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

  alsu_cmd_sequencer #(.DEPTH(DEPTH), .IDLE_OPCODE(3'b000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [16:0] mk(bit s, logic [2:0] op, logic [2:0] a, logic [2:0] b,
                                     bit cin, bit ra, bit rb, bit ba, bit bb, bit dir, bit sin);
    return {s, op, a, b, cin, ra, rb, ba, bb, dir, sin};
  endfunction

  function automatic logic [18:0] dut_out();
    return {bus.issue_valid, bus.seq_busy, bus.seq_done, bus.alsu_opcode, bus.alsu_A, bus.alsu_B,
            bus.alsu_cin, bus.alsu_red_op_A, bus.alsu_red_op_B, bus.alsu_bypass_A,
            bus.alsu_bypass_B, bus.alsu_direction, bus.alsu_serial_in};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: one clock edge worth of behaviour, expressed on queues
  task automatic model_step(input bit v, input logic [16:0] d, input bit h);
    bit          acc, iv, busy, done;
    logic [15:0] w;
    logic [16:0] c;
    exp_t        e;
    acc = v && (pend_q.size() < DEPTH);
    if (h) begin
      w = 16'd0; iv = 1'b0; busy = last_busy; done = 1'b0;
    end else if (burst_q.size() > 0) begin
      w = burst_q.pop_front(); iv = 1'b1; busy = 1'b1; done = (burst_q.size() == 0);
    end else if (pend_q.size() > 0) begin
      c = pend_q.pop_front(); iv = 1'b1; done = 1'b0;
      if (c[16]) begin
        for (int k = 0; k < 6; k++)
          burst_q.push_back({3'(k), c[12:7], c[6], 4'b0000, c[1:0]});
        w = burst_q.pop_front(); busy = 1'b1;
      end else begin
        w = c[15:0]; busy = 1'b0;
      end
    end else begin
      w = 16'd0; iv = 1'b0; busy = 1'b0; done = 1'b0;
    end
    last_busy = busy;
    if (acc) pend_q.push_back(d);
    e.out   = {iv, busy, done, w};
    e.ready = (pend_q.size() < DEPTH);
    e.count = CW'(pend_q.size());
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus (called just after a falling edge)
  task automatic cyc(input bit v, input logic [16:0] d, input bit h);
    bus.cmd_valid = v;
    bus.cmd_data  = d;
    bus.hold      = h;
    @(posedge clk);
    model_step(v, d, h);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 17'd0, 1'b0);
  endtask

  // Monitor: compare DUT outputs with the scoreboard on every falling edge
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("issue_word", 32'(dut_out()), 32'(mon_e.out));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(mon_e.ready));
      chk("fifo_count", 32'(bus.fifo_count), 32'(mon_e.count));
    end
  end

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 17'd0;
    bus.hold      = 1'b0;
    last_busy     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_word", 32'(dut_out()), 32'd0);
    chk("reset_count", 32'(bus.fifo_count), 32'd0);
    chk("reset_ready", 32'(bus.cmd_ready), 32'd1);

    // Single ADD, A=3, B=-2, cin=1
    cyc(1'b1, mk(1'b0, 3'd2, 3'd3, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    idle(3);

    // Burst with opcode 7 and flags that must be cleared
    cyc(1'b1, mk(1'b1, 3'd7, 3'b111, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), 1'b0);
    idle(8);

    // Fill under hold, a fifth word is dropped, then drain
    for (int i = 0; i < 5; i++)
      cyc(1'b1, mk(1'b0, 3'(i + 1), 3'(i), 3'(7 - i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
    idle(6);

    // Hold for two cycles in the middle of a burst
    cyc(1'b1, mk(1'b1, 3'd0, 3'd5, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0);
    idle(3);
    cyc(1'b0, 17'd0, 1'b1);
    cyc(1'b0, 17'd0, 1'b1);
    idle(6);

    // Burst followed by an opcode-6 single command
    cyc(1'b1, mk(1'b1, 3'd3, 3'd1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
    cyc(1'b1, mk(1'b0, 3'd6, 3'd2, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
    idle(9);

    // Asynchronous reset mid-burst with three words queued
    cyc(1'b1, mk(1'b1, 3'd0, 3'd6, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, mk(1'b0, 3'd1, 3'(i), 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    bus.cmd_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_word", 32'(dut_out()), 32'd0);
    chk("async_rst_count", 32'(bus.fifo_count), 32'd0);
    chk("async_rst_ready", 32'(bus.cmd_ready), 32'd1);
    pend_q.delete();
    burst_q.delete();
    exp_q.delete();
    last_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [16:0] d;
      d = 17'($urandom);
      d[16] = ($urandom_range(0, 3) == 0);
      cyc(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 4) == 0));
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alsu_cmd_sequencer.md
Name: alsu_cmd_sequencer

Overview:
- Upstream feeder for the ALSU.
- Accepts packed ALSU command words over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per clock onto the ALSU's registered input pins.
- A command with seq_mode set expands into the fixed six-opcode burst OR, XOR, ADD, MULT, SHIFT, ROTATE on the same operands, so the ALSU's shift/rotate chain is exercised back-to-back.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- IDLE_OPCODE, 3'b000 (OR), opcode driven when no command issues; with zero operands the ALSU output is 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command word presented.
- cmd_ready  out  1  FIFO can accept (combinational, = !full).
- cmd_data  in  17  {seq_mode[16], opcode[15:13], A[12:10], B[9:7], cin[6], red_op_A[5], red_op_B[4], bypass_A[3], bypass_B[2], direction[1], serial_in[0]}.
- hold  in  1  downstream stall; freezes issuing.
- alsu_opcode  out  3  registered, to ALSU opcode.
- alsu_A, alsu_B  out  3 each  registered signed operands.
- alsu_cin, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction, alsu_serial_in  out  1 each  registered ALSU controls.
- issue_valid  out  1  registered; 1 when the alsu_* word is a real command.
- seq_busy  out  1  registered; 1 while a burst is in progress.
- seq_done  out  1  registered one-cycle pulse with the ROTATE step of a burst.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst=1): FIFO emptied, state IDLE, step=0.
  - All alsu_* outputs 0, except alsu_opcode = IDLE_OPCODE.
  - issue_valid, seq_busy, seq_done all 0; fifo_count 0.
  - Reset mid-burst abandons the burst; the remaining steps are never issued.
- Push: on each rising edge with cmd_valid && cmd_ready, cmd_data is written at the write pointer.
  - Pointers wrap modulo DEPTH.
  - When full, cmd_ready=0 and cmd_valid is ignored, even if a pop occurs in the same cycle.
- Pop and issue latency: a word pushed at edge N issues at edge N+1 at the earliest. There is no fall-through path. Order is strictly FIFO.
- State machine (registered): IDLE, SINGLE, SEQ.
  - hold=1:
    - State, step and FIFO are frozen; no pop.
    - Outputs take the idle word: opcode=IDLE_OPCODE, all other alsu_* = 0, issue_valid=0.
    - seq_busy keeps its value; seq_done=0.
  - SEQ with step<5, hold=0:
    - step++ and alsu_opcode = table[step]; table = {OR, XOR, ADD, MULT, SHIFT, ROTATE} = {0,1,2,3,4,5}.
    - Operands and cin/direction/serial_in are held from the burst's command.
    - No pop.
    - At step 5 (ROTATE), seq_done=1. The next edge leaves SEQ, dropping seq_busy, and may pop.
  - Otherwise, FIFO non-empty, hold=0: pop head.
    - seq_mode=1:
      - Enter SEQ with step 0 and issue OR; seq_busy=1, issue_valid=1.
      - red_op_A, red_op_B, bypass_A and bypass_B are forced to 0 for the whole burst.
      - The command's opcode field is ignored.
    - seq_mode=0:
      - Enter SINGLE and issue all fields unchanged, including opcodes 6/7 and illegal red_op combinations; the ALSU flags those.
      - issue_valid=1.
  - Otherwise, FIFO empty: go to IDLE and drive the idle word with issue_valid=0.
- Throughput:
  - Single commands issue back-to-back, one per cycle, with no bubble.
  - A burst occupies exactly 6 issue cycles.
  - A command queued behind a burst issues at the cycle immediately after ROTATE.
- fifo_count:
  - +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - Never exceeds DEPTH and never underflows.

Test Plan:
- Reset: assert rst asynchronously between edges with 3 entries queued and a burst at step 2 → outputs zero immediately, fifo_count=0, cmd_ready=1; after release, no stale command issues.
- Single command: push {seq=0, op=ADD(2), A=3, B=-2, cin=1} at edge N → at edge N+1 alsu_opcode=2, alsu_A=3, alsu_B=-2 (3'b110), alsu_cin=1, issue_valid=1; at N+2 idle word, issue_valid=0.
- Burst: push {seq=1, op=7, A=-1, B=2, red_op_A=1, bypass_B=1, direction=1, serial_in=1}:
  - Opcodes 0,1,2,3,4,5 on six consecutive edges, A=-1 and B=2 throughout.
  - red_op_A=0 and bypass_B=0 throughout.
  - seq_done=1 only with opcode 5; seq_busy high for the 6 cycles.
- Full/backpressure: with hold=1, push 4 commands → cmd_ready=0 and fifo_count=4; a 5th cmd_valid is dropped. Release hold → 4 issues in push order, with cmd_ready=1 after the first pop.
- Hold mid-burst: assert hold for 2 cycles at step 3 → two idle words (issue_valid=0, seq_busy=1); then MULT, SHIFT, ROTATE resume with no step skipped or repeated.
- Burst followed by single: queue a burst then {seq=0, op=6} → ROTATE at cycle k, opcode 6 issued unchanged at k+1, issue_valid=1.
